// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: valid/ready in, valid/ready out, status flags.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       operator;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, operator, out_ready,
    input  in_ready, out_valid, c, carry, zero, ovf, op_count
  );

  modport slave (
    input  in_valid, a, b, operator, out_ready,
    output in_ready, out_valid, c, carry, zero, ovf, op_count
  );
endinterface

// File: rtl/alu_pipe.sv
// 2-stage valid/ready ALU: S1 holds operands, S2 holds result+flags; 2-cycle latency, a stall fills S1 then drops in_ready.
// Define ALU_SAT_EN for signed saturation of ADD/SUB on overflow (default: wrap).
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      reset,
  alu_pipe_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SLL   = 3'd5;
  localparam logic [2:0] OP_SRL   = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_c;
  logic             r_s2_carry;
  logic             r_s2_zero;
  logic             r_s2_ovf;

  logic [CNT_W-1:0] r_op_count;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_c_fin;
  logic             w_carry;
  logic             w_ovf;
  logic             w_zero;

  // S2 may advance whenever it is empty or being drained; S1 follows S2.
  assign w_adv2   = !r_s2_valid || bus.out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign w_accept = bus.in_valid && w_adv1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= OP_ADD;
    end else if (w_adv1) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_a  <= bus.a;
        r_s1_b  <= bus.b;
        r_s1_op <= bus.operator;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_count <= '0;
    end else if (w_accept) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};
  assign w_sh   = r_s1_b[SH_W-1:0];

  always_comb begin
    w_c     = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_c     = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
      end
      OP_SUB: begin
        // The extra top bit of the unsigned difference is the borrow (a < b).
        w_c     = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);
      end
      OP_AND:   w_c = r_s1_a & r_s1_b;
      OP_OR:    w_c = r_s1_a | r_s1_b;
      OP_XOR:   w_c = r_s1_a ^ r_s1_b;
      OP_SLL:   w_c = r_s1_a << w_sh;
      OP_SRL:   w_c = r_s1_a >> w_sh;
      OP_PASSB: w_c = r_s1_b;
      default:  w_c = '0;
    endcase
  end

`ifdef ALU_SAT_EN
  // On overflow the true result's sign is the sign of a for both ADD and SUB.
  assign w_c_fin = (w_ovf && r_s1_a[MSB]) ? {1'b1, {(WIDTH-1){1'b0}}} :
                   w_ovf                  ? {1'b0, {(WIDTH-1){1'b1}}} :
                                            w_c;
`else
  assign w_c_fin = w_c;
`endif

  assign w_zero = (w_c_fin == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_c     <= '0;
      r_s2_carry <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_ovf   <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_c     <= w_c_fin;
        r_s2_carry <= w_carry;
        r_s2_zero  <= w_zero;
        r_s2_ovf   <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = w_adv1;
  assign bus.out_valid = r_s2_valid;
  assign bus.c         = r_s2_c;
  assign bus.carry     = r_s2_carry;
  assign bus.zero      = r_s2_zero;
  assign bus.ovf       = r_s2_ovf;
  assign bus.op_count  = r_op_count;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8, CNT_W=4): directed corner cases, stall/reset scenarios, then random traffic
// scored against an arithmetic reference model and an in-flight queue.
module tb_alu_pipe;
  localparam int W = 8;
  localparam int CW = 4;

  typedef struct {
    int c;
    bit carry;
    bit zero;
    bit ovf;
    int stamp;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   cnt = 0;
  exp_t q[$];
  bit   acc;

  alu_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_alu(int a, int b, int op);
    exp_t r;
    int sa, sb, t, sh;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sh = b % 8;
    r.carry = 0;
    r.ovf = 0;
    r.stamp = 0;
    case (op)
      0: begin
        r.c = (a + b) % 256;
        r.carry = (a + b) > 255;
        t = sa + sb;
        r.ovf = (t > 127) || (t < -128);
      end
      1: begin
        r.c = (a - b + 256) % 256;
        r.carry = a < b;
        t = sa - sb;
        r.ovf = (t > 127) || (t < -128);
      end
      2: r.c = a & b;
      3: r.c = a | b;
      4: r.c = a ^ b;
      5: r.c = (a << sh) % 256;
      6: r.c = a >> sh;
      default: r.c = b;
    endcase
`ifdef ALU_SAT_EN
    if (r.ovf) r.c = (t > 127) ? 127 : 128;
`endif
    r.zero = (r.c == 0);
    return r;
  endfunction

  // One clock: judge handshakes at the falling edge, advance, then check the counter.
  task automatic step(output bit accepted);
    exp_t e;
    accepted = 0;
    @(negedge clk);
    check("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
    check("out_valid", 32'(bus.out_valid), 32'((q.size() > 0) && (cyc >= q[0].stamp + 2)));
    if (bus.out_valid && bus.out_ready && q.size() > 0) begin
      e = q.pop_front();
      check("c", 32'(bus.c), 32'(e.c));
      check("carry", 32'(bus.carry), 32'(e.carry));
      check("zero", 32'(bus.zero), 32'(e.zero));
      check("ovf", 32'(bus.ovf), 32'(e.ovf));
    end
    if (bus.in_valid && bus.in_ready) begin
      e = ref_alu(int'(bus.a), int'(bus.b), int'(bus.operator));
      e.stamp = cyc;
      q.push_back(e);
      cnt = (cnt + 1) % 16;
      accepted = 1;
    end
    @(posedge clk);
    cyc++;
    #1;
    check("op_count", 32'(bus.op_count), 32'(cnt));
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.operator = op;
    for (int k = 0; k < 50 && !ok; k++) step(ok);
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    check("rst_c", 32'(bus.c), 32'd0);
    check("rst_flags", {29'd0, bus.carry, bus.zero, bus.ovf}, 32'd0);
    q.delete();
    cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    bit d;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) step(d);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [7:0] ec,
                          input bit ecy, input bit ez, input bit eo);
    bit d;
    bus.out_ready = 1'b1;
    send_beat(a, b, op);
    step(d);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_c"}, 32'(bus.c), 32'(ec));
    check({tag, "_flags"}, {29'd0, bus.carry, bus.zero, bus.ovf}, {29'd0, ecy, ez, eo});
    drain();
  endtask

  logic [7:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.operator = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    directed("add_wrap", 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0);
`ifdef ALU_SAT_EN
    directed("add_ovf", 8'h7F, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b1);
`else
    directed("add_ovf", 8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1);
`endif
    directed("sub_borrow", 8'h03, 8'h05, 3'd1, 8'hFE, 1'b1, 1'b0, 1'b0);
    directed("srl_trunc", 8'h80, 8'h0B, 3'd6, 8'h10, 1'b0, 1'b0, 1'b0);

    // Back-to-back beats with the consumer stalled after the first cycle.
    do_reset();
    bus.out_ready = 1'b1;
    send_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    bus.out_ready = 1'b0;
    send_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    bus.in_valid = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'hA5;
    bus.operator = 3'd4;
    for (int k = 0; k < 4; k++) step(acc);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_count", 32'(bus.op_count), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 2; i < 8; i++)
      send_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    drain();
    check("stall_total", 32'(bus.op_count), 32'd8);

    // Reset with two beats in flight; nothing may surface afterwards.
    bus.out_ready = 1'b0;
    send_beat(8'h11, 8'h22, 3'd0);
    send_beat(8'h33, 8'h44, 3'd1);
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step(acc);

    // Counter wrap at 2^CNT_W.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    check("wrap_count", 32'(bus.op_count), 32'd1);
    drain();

    acc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
        bus.b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
        bus.operator = 3'($urandom_range(0, 7));
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step(acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
